music_fetcher: RTL and testbench

MUSIC_FETCHER -- requirements
Module: music_fetcher

---
 rtl/music_fetcher.sv | 173 +++++++++++++++++
 tb/tb_music_fetcher.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_fetcher.sv
// Streams 16-bit stereo-packed audio words out of an Avalon flash port and plays
// the high byte of each sample at the audio rate, forward or backward through memory.
module music_fetcher #(
  parameter logic [22:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sample_freq_div,
  input  logic        pause,
  input  logic        forward,
  input  logic        fetcher_reset,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic        flash_mem_waitrequest,
  input  logic        flash_mem_readdatavalid,
  input  logic [31:0] flash_mem_readdata,
  output logic [7:0]  audio_data,
  output logic        audio_valid
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_DATA = 2'd1,
    PLAY1     = 2'd2,
    PLAY2     = 2'd3
  } state_t;

  state_t      state_r;
  logic [22:0] addr_r;
  logic [31:0] cnt_r;
  logic [31:0] word_r;
  logic        pend_r;
  logic        read_r;
  logic        first_fwd_r;
  logic [7:0]  audio_data_r;
  logic        audio_valid_r;

  logic [31:0] div_m1_s;
  logic        tick_s;
  logic        reset_req_s;
  logic [22:0] reset_addr_s;
  logic [7:0]  first_byte_s;
  logic [7:0]  second_byte_s;
  logic        unused_word_s;

  // Wrapping single-word step through the flash address space.
  function automatic logic [22:0] step_addr(input logic [22:0] addr, input logic fwd);
    logic [22:0] nxt;
    if (fwd) begin
      if (addr == MAX_ADDR) nxt = 23'd0;
      else                  nxt = addr + 23'd1;
    end else begin
      if (addr == 23'd0) nxt = MAX_ADDR;
      else               nxt = addr - 23'd1;
    end
    return nxt;
  endfunction

  assign flash_mem_read       = read_r;
  assign flash_mem_address    = addr_r;
  assign flash_mem_byteenable = 4'hF;
  assign audio_data           = audio_data_r;
  assign audio_valid          = audio_valid_r;

  // Only the high byte of each 16-bit sample reaches the 8-bit output.
  assign unused_word_s = ^{word_r[7:0], word_r[23:16]};

  // Divider terminal count, restart request and sample byte selection.
  always_comb begin
    div_m1_s      = 32'd0;
    reset_addr_s  = 23'd0;
    first_byte_s  = 8'h00;
    second_byte_s = 8'h00;
    if (sample_freq_div > 32'd1) div_m1_s = sample_freq_div - 32'd1;
    else                         div_m1_s = 32'd0;
    tick_s      = ~pause & (cnt_r >= div_m1_s);
    reset_req_s = pend_r | fetcher_reset;
    if (forward) reset_addr_s = 23'd0;
    else         reset_addr_s = MAX_ADDR;
    if (forward) first_byte_s = word_r[15:8];
    else         first_byte_s = word_r[31:24];
    // The second half is always the one not played first, whatever forward is now.
    if (first_fwd_r) second_byte_s = word_r[31:24];
    else             second_byte_s = word_r[15:8];
  end

  // Sample-rate divider, flash transaction sequencing and registered sample output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FETCH;
      addr_r        <= 23'd0;
      cnt_r         <= 32'd0;
      word_r        <= 32'd0;
      pend_r        <= 1'b0;
      read_r        <= 1'b0;
      first_fwd_r   <= 1'b0;
      audio_data_r  <= 8'h00;
      audio_valid_r <= 1'b0;
    end else begin
      audio_valid_r <= 1'b0;
      pend_r        <= pend_r | fetcher_reset;
      if (!pause) begin
        if (tick_s) cnt_r <= 32'd0;
        else        cnt_r <= cnt_r + 32'd1;
      end
      case (state_r)
        FETCH: begin
          if (!read_r) begin
            read_r <= 1'b1;
            if (reset_req_s) begin
              addr_r <= reset_addr_s;
              cnt_r  <= 32'd0;
              pend_r <= 1'b0;
            end
          end else if (!flash_mem_waitrequest) begin
            read_r  <= 1'b0;
            state_r <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (flash_mem_readdatavalid) begin
            // A restart requested mid-transaction discards the returned word.
            if (reset_req_s) begin
              addr_r  <= reset_addr_s;
              cnt_r   <= 32'd0;
              pend_r  <= 1'b0;
              read_r  <= 1'b1;
              state_r <= FETCH;
            end else begin
              word_r  <= flash_mem_readdata;
              state_r <= PLAY1;
            end
          end
        end
        PLAY1: begin
          if (pend_r) begin
            addr_r  <= reset_addr_s;
            cnt_r   <= 32'd0;
            pend_r  <= 1'b0;
            read_r  <= 1'b1;
            state_r <= FETCH;
          end else if (!fetcher_reset && tick_s) begin
            audio_data_r  <= first_byte_s;
            audio_valid_r <= 1'b1;
            first_fwd_r   <= forward;
            state_r       <= PLAY2;
          end
        end
        PLAY2: begin
          if (pend_r) begin
            addr_r  <= reset_addr_s;
            cnt_r   <= 32'd0;
            pend_r  <= 1'b0;
            read_r  <= 1'b1;
            state_r <= FETCH;
          end else if (!fetcher_reset && tick_s) begin
            audio_data_r  <= second_byte_s;
            audio_valid_r <= 1'b1;
            addr_r        <= step_addr(addr_r, forward);
            read_r        <= 1'b1;
            state_r       <= FETCH;
          end
        end
        default: begin
          read_r  <= 1'b0;
          state_r <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_music_fetcher.sv
// Bench for music_fetcher: Avalon flash responder plus a word-stream reference model
// that predicts read addresses and played bytes from direction, wrap and restart rules.
module tb_music_fetcher;

  localparam logic [22:0] MAX_ADDR = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sample_freq_div;
  logic        pause;
  logic        forward;
  logic        fetcher_reset;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest   = 1'b0;
  logic        flash_mem_readdatavalid = 1'b0;
  logic [31:0] flash_mem_readdata      = 32'd0;
  logic [7:0]  audio_data;
  logic        audio_valid;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cycle_cnt = 0;
  int          stall_n = 0;
  int          lat_n = 2;
  int          stall_cnt = 0;
  int          dcnt = 0;
  logic [22:0] pend_addr = 23'd0;
  logic [22:0] acc_q[$];
  logic [22:0] m_addr;
  bit          rnd_pause = 1'b0;

  music_fetcher #(.MAX_ADDR(MAX_ADDR)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .sample_freq_div         (sample_freq_div),
    .pause                   (pause),
    .forward                 (forward),
    .fetcher_reset           (fetcher_reset),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .flash_mem_readdata      (flash_mem_readdata),
    .audio_data              (audio_data),
    .audio_valid             (audio_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_at(input logic [22:0] a);
    if (a == 23'd0 || a == 23'd5) return 32'h1234ABCD;
    return ({9'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [22:0] next_addr(input logic [22:0] a, input bit fwd);
    int unsigned n;
    int unsigned r;
    n = 32'(MAX_ADDR) + 32'd1;
    if (fwd) r = (32'(a) + 32'd1) % n;
    else     r = (32'(a) + n - 32'd1) % n;
    return 23'(r);
  endfunction

  function automatic logic [7:0] samp_byte(input logic [31:0] w, input bit sample_a);
    if (sample_a) return w[15:8];
    return w[31:24];
  endfunction

  // Flash slave: optional stall before acceptance, fixed data latency afterwards.
  always @(negedge clk) begin
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = $urandom;
    if (rst) begin
      dcnt = 0;
      stall_cnt = 0;
      flash_mem_waitrequest = 1'b0;
      acc_q.delete();
    end else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata      = word_at(pend_addr);
        end
      end
      if (flash_mem_read) begin
        if (stall_cnt < stall_n) begin
          flash_mem_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          flash_mem_waitrequest = 1'b0;
          stall_cnt = 0;
          acc_q.push_back(flash_mem_address);
          pend_addr = flash_mem_address;
          dcnt = lat_n;
        end
      end else begin
        flash_mem_waitrequest = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_pause) pause = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_read(input string tag);
    int budget;
    bit seen;
    budget = 300;
    seen = 1'b0;
    while (acc_q.size() == 0 && budget > 0) begin
      step();
      if (audio_valid) seen = 1'b1;
      budget--;
    end
    check({tag, "_rd_count"}, 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check({tag, "_rd_addr"}, 32'(acc_q.pop_front()), 32'(m_addr));
    check({tag, "_no_strobe"}, 32'(seen), 32'd0);
  endtask

  task automatic expect_strobe(input string tag, input logic [7:0] exp, output int t);
    int cyc;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!audio_valid && cyc < 400);
    check({tag, "_valid"}, 32'(audio_valid), 32'd1);
    check({tag, "_data"}, 32'(audio_data), 32'(exp));
    t = cycle_cnt;
  endtask

  task automatic play_samples(input string tag, input bit f1, input bit f2,
                              output int t1, output int t2);
    logic [31:0] w;
    w = word_at(m_addr);
    forward = f1;
    expect_strobe({tag, "_s1"}, samp_byte(w, f1), t1);
    forward = f2;
    expect_strobe({tag, "_s2"}, samp_byte(w, !f1), t2);
    m_addr = next_addr(m_addr, f2);
  endtask

  task automatic play_word(input string tag, input bit f1, input bit f2,
                           output int t1, output int t2);
    forward = f1;
    wait_read(tag);
    play_samples(tag, f1, f2, t1, t2);
  endtask

  initial begin
    int t1, t2, t3, t4, rel;
    bit seen;
    bit moved;
    logic [7:0] saved;
    bit f, g;

    rst = 1'b1;
    pause = 1'b0;
    forward = 1'b1;
    fetcher_reset = 1'b0;
    sample_freq_div = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read", 32'(flash_mem_read), 32'd0);
    check("rst_data", 32'(audio_data), 32'h00);
    check("rst_valid", 32'(audio_valid), 32'd0);
    check("byteenable", 32'(flash_mem_byteenable), 32'hF);
    rst = 1'b0;
    step();
    check("first_read", 32'(flash_mem_read), 32'd1);
    check("first_addr", 32'(flash_mem_address), 32'd0);
    m_addr = 23'd0;

    // Forward play at div 4 with zero stall and latency 2.
    play_word("fwd0", 1'b1, 1'b1, t1, t2);
    check("fwd0_gap", 32'(t2 - t1), 32'd4);
    play_word("fwd1", 1'b1, 1'b1, t3, t4);
    check("fwd_word_gap", 32'(t3 - t2), 32'd4);
    step();
    check("strobe_pulse", 32'(audio_valid), 32'd0);
    for (int i = 2; i < 5; i++) play_word("fwd_n", 1'b1, 1'b1, t1, t2);

    // Backward play of the word at address 5.
    play_word("bwd5", 1'b0, 1'b0, t1, t2);

    // Three-cycle stall on the read of address 4.
    stall_n = 3;
    seen = 1'b0;
    for (int i = 0; i < 20 && !flash_mem_read; i++) step();
    for (int i = 0; i < 4; i++) begin
      check("stall_hold", {8'd0, flash_mem_read, flash_mem_address}, {8'd0, 1'b1, m_addr});
      if (i < 3) step();
    end
    step();
    check("stall_drop", 32'(flash_mem_read), 32'd0);
    stall_n = 0;
    play_word("after_stall", 1'b1, 1'b1, t1, t2);

    // Direction flips between the two halves of one word.
    play_word("mid_flip", 1'b1, 1'b0, t1, t2);

    // Pause right after a word completes; the fetch still finishes meanwhile.
    pause = 1'b1;
    saved = audio_data;
    seen = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (audio_valid) seen = 1'b1;
      if (audio_data !== saved) moved = 1'b1;
    end
    check("pause_no_valid", 32'(seen), 32'd0);
    check("pause_data_hold", 32'(moved), 32'd0);
    forward = 1'b0;
    wait_read("pause");
    pause = 1'b0;
    rel = cycle_cnt;
    play_samples("pause_rel", 1'b0, 1'b0, t1, t2);
    check("pause_release_gap", 32'(t1 - rel), 32'd4);

    // Restart while the data phase is outstanding, playing backward at div 1.
    lat_n = 5;
    saved = audio_data;
    wait_read("rst_wd");
    forward = 1'b0;
    fetcher_reset = 1'b1;
    sample_freq_div = 32'd1;
    step();
    fetcher_reset = 1'b0;
    lat_n = 2;
    m_addr = MAX_ADDR;
    wait_read("rst_wd_next");
    check("rst_wd_data_hold", 32'(audio_data), 32'(saved));
    play_samples("max_bwd", 1'b0, 1'b0, t1, t2);
    check("div1_gap", 32'(t2 - t1), 32'd1);
    play_word("max1_fwd", 1'b1, 1'b1, t1, t2);
    play_word("wrap_fwd", 1'b1, 1'b1, t1, t2);
    play_word("wrap_bwd", 1'b0, 1'b0, t1, t2);
    play_word("wrap_fwd2", 1'b1, 1'b1, t1, t2);

    // Restart while waiting in PLAY1 for a slow tick.
    sample_freq_div = 32'd30;
    forward = 1'b1;
    wait_read("rst_play");
    repeat (8) step();
    forward = 1'b0;
    fetcher_reset = 1'b1;
    step();
    fetcher_reset = 1'b0;
    m_addr = MAX_ADDR;
    play_word("after_play_rst", 1'b0, 1'b0, t1, t2);
    check("div30_gap", 32'(t2 - t1), 32'd30);

    // Randomised divider, stalls, latency, direction and pause.
    rnd_pause = 1'b1;
    for (int i = 0; i < 24; i++) begin
      sample_freq_div = $urandom_range(0, 6);
      lat_n = $urandom_range(1, 4);
      stall_n = $urandom_range(0, 2);
      f = 1'($urandom_range(0, 1));
      g = ($urandom_range(0, 3) == 0) ? !f : f;
      play_word("rnd", f, g, t1, t2);
    end
    rnd_pause = 1'b0;
    pause = 1'b0;
    stall_n = 0;

    // System reset in the middle of a transaction.
    lat_n = 4;
    wait_read("pre_rst");
    rst = 1'b1;
    step();
    check("mid_rst_read", 32'(flash_mem_read), 32'd0);
    check("mid_rst_valid", 32'(audio_valid), 32'd0);
    check("mid_rst_data", 32'(audio_data), 32'h00);
    rst = 1'b0;
    step();
    check("post_rst_read", 32'(flash_mem_read), 32'd1);
    check("post_rst_addr", 32'(flash_mem_address), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
